// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle between the PC sequencer and instruction memory/decode.
// The sequencer side takes the master modport.
interface pc_fetch_if;
    logic        Stall;
    logic [31:0] Inst;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic [31:0] Addr;
    logic [31:0] PcPlus4;
    logic        FetchValid;
    logic        Fault;
    logic [31:0] Retired;

    modport master (
        input  Stall, Inst, Branch, Jump, JumpReg, RegTarget,
        output Addr, PcPlus4, FetchValid, Fault, Retired
    );

    modport slave (
        output Stall, Inst, Branch, Jump, JumpReg, RegTarget,
        input  Addr, PcPlus4, FetchValid, Fault, Retired
    );
endinterface

// File: rtl/pc_fetch.sv
// PC register and next-PC sequencing for the single-cycle MIPS core.
// Optional fetch-fault trapping is enabled by defining PC_FAULT_EN.
module pc_fetch #(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    pc_fetch_if.master  f
);

`ifdef PC_FAULT_EN
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
`else
    typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] retired, retired_nx;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        unused_bits;

    assign unused_bits = ^{f.Inst[31:26], DEPTH[0]};

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{f.Inst[15]}}, f.Inst[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (f.JumpReg)
            next_pc = f.RegTarget;
        else if (f.Jump)
            next_pc = {pc_plus4[31:28], f.Inst[25:0], 2'b00};
        else if (f.Branch)
            next_pc = pc_plus4 + br_off;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            retired <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            retired <= retired_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        retired_nx = retired;
        unique case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (!f.Stall) begin
`ifdef PC_FAULT_EN
                    // Trap keeps the faulting PC and leaves it uncounted.
                    if (next_pc[1:0] != 2'b00 ||
                        {1'b0, next_pc} >= LIMIT) begin
                        state_nx = FAULT;
                    end else begin
                        pc_nx      = next_pc;
                        retired_nx = retired + 32'd1;
                    end
`else
                    pc_nx      = {next_pc[31:2], 2'b00};
                    retired_nx = retired + 32'd1;
`endif
                end
            end
`ifdef PC_FAULT_EN
            FAULT: state_nx = FAULT;
`endif
            default: state_nx = BOOT;
        endcase
    end

    assign f.Addr       = pc;
    assign f.PcPlus4    = pc_plus4;
    assign f.FetchValid = (state == RUN);
    assign f.Retired    = retired;
`ifdef PC_FAULT_EN
    assign f.Fault      = (state == FAULT);
`else
    assign f.Fault      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: expected PC/retire state is queued per step
// and compared one cycle later against the DUT outputs.
module tb_pc_fetch;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ret;
        logic        fv;
        logic        flt;
    } exp_t;

    exp_t  q[$];
    string tq[$];

    pc_fetch_if f();

    pc_fetch #(.DEPTH(32), .RESET_PC(32'h0)) dut (
        .Clk   (clk),
        .Reset (rst),
        .f     (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, req);
        end
    endtask

    task automatic ctl(input logic st, input logic br, input logic jp,
                       input logic jr, input logic [31:0] inst,
                       input logic [31:0] tgt);
        f.Stall     = st;
        f.Branch    = br;
        f.Jump      = jp;
        f.JumpReg   = jr;
        f.Inst      = inst;
        f.RegTarget = tgt;
    endtask

    task automatic step(input string tag, input logic [31:0] a,
                        input logic [31:0] r, input logic v, input logic e);
        exp_t x;
        string t;
        q.push_back('{addr: a, ret: r, fv: v, flt: e});
        tq.push_back(tag);
        @(posedge clk);
        #1;
        x = q.pop_front();
        t = tq.pop_front();
        chk32({t, ".addr"}, f.Addr, x.addr);
        chk32({t, ".ret"}, f.Retired, x.ret);
        chk1({t, ".fv"}, f.FetchValid, x.fv);
        chk1({t, ".fault"}, f.Fault, x.flt);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        step("reset", 32'h0, 32'd0, 1'b0, 1'b0);
        chk32("reset.pcplus4", f.PcPlus4, 32'h4);

        rst = 1'b0;
        step("run0", 32'h00, 32'd0, 1'b1, 1'b0);
        step("seq4", 32'h04, 32'd1, 1'b1, 1'b0);
        step("seq8", 32'h08, 32'd2, 1'b1, 1'b0);
        chk32("pcplus4.8", f.PcPlus4, 32'h0C);

        ctl(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000FFFF, 32'h0);
        step("br.self", 32'h08, 32'd3, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("seqC", 32'h0C, 32'd4, 1'b1, 1'b0);
        ctl(1'b0, 1'b1, 1'b0, 1'b0, 32'h10220001, 32'h0);
        step("br.taken", 32'h14, 32'd5, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0C);
        step("jr.backC", 32'h0C, 32'd6, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h10220001, 32'h0);
        step("br.nt", 32'h10, 32'd7, 1'b1, 1'b0);

        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h20);
        step("jr.20", 32'h20, 32'd8, 1'b1, 1'b0);
        ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h10220001, 32'h0);
        step("stall1", 32'h20, 32'd8, 1'b1, 1'b0);
        step("stall2", 32'h20, 32'd8, 1'b1, 1'b0);
        step("stall3", 32'h20, 32'd8, 1'b1, 1'b0);
        f.Stall = 1'b0;
        step("unstall.br", 32'h28, 32'd9, 1'b1, 1'b0);

        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h5C);
        step("jr.5C", 32'h5C, 32'd10, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0, 32'h08000019, 32'h0);
        step("jump", 32'h64, 32'd11, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h5C);
        step("jr.5C.b", 32'h5C, 32'd12, 1'b1, 1'b0);
        ctl(1'b0, 1'b1, 1'b1, 1'b1, 32'h08000019, 32'h10);
        step("jr.prio", 32'h10, 32'd13, 1'b1, 1'b0);

`ifdef PC_FAULT_EN
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h22222222);
        step("fault", 32'h10, 32'd13, 1'b0, 1'b1);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("fault.hold", 32'h10, 32'd13, 1'b0, 1'b1);
`else
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h23);
        step("jr.mask", 32'h20, 32'd14, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h22222222);
        step("jr.alias", 32'h22222220, 32'd15, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFC);
        step("jr.top", 32'hFFFFFFFC, 32'd16, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("pc.wrap", 32'h0, 32'd17, 1'b1, 1'b0);
`endif

        rst = 1'b1;
        ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h10220001, 32'h0);
        step("rst.again", 32'h0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        f.Stall = 1'b0;
        step("rst.boot", 32'h0, 32'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-sequencing stage of the single-cycle MIPS core, directly upstream of the instruction memory. Holds the registered PC, drives it as the memory address, takes the returned instruction word back, and computes the next PC: sequential, branch, jump/jal, or jr. Also provides the jal link value, a fetch-valid qualifier for downstream decode, and a retired-instruction counter.

## Interface
- DEPTH, 32, instruction memory depth in words; legal fetch range 0 .. DEPTH*4-4
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  hold PC and counter this cycle
- Inst  in  32  instruction word returned by instruction memory for Addr
- Branch  in  1  resolved conditional branch taken (beq/bne outcome from decode/ALU)
- Jump  in  1  j or jal in current instruction
- JumpReg  in  1  jr in current instruction
- RegTarget  in  32  rs register value for jr
- Addr  out  32  current PC, to instruction memory address
- PcPlus4  out  32  Addr+4; jal link value
- FetchValid  out  1  Inst at Addr is to be executed this cycle
- Fault  out  1  fetch fault latched (only with PC_FAULT_EN)
- Retired  out  32  count of instructions committed since reset

## Operation
- States: BOOT, RUN, FAULT.
- Reset (any state): PC=RESET_PC, state=BOOT, Retired=0, Fault=0.
- BOOT: FetchValid=0; PC holds; unconditional transition to RUN next edge.
- RUN: FetchValid=1. If Stall=1: PC and Retired hold. Else PC<=NextPc, Retired<=Retired+1.
- NextPc priority: JumpReg > Jump > Branch > sequential.
  - sequential: PC+4
  - branch: PC+4 + (sign_extend(Inst[15:0]) << 2)
  - jump: {PcPlus4[31:28], Inst[25:0], 2'b00}
  - jr: RegTarget
- All additions modulo 2^32; wrap from 32'hFFFF_FFFC to 0 silently.
- Control inputs ignored in BOOT and FAULT, and when Stall=1.
- Retired wraps from 32'hFFFF_FFFF to 0.
- Outputs: PcPlus4 combinational from PC; FetchValid, Fault decoded from state.

## Timing
- Addr is a register output; Inst returns combinationally in the same cycle; NextPc computed combinationally and loaded on the next rising edge. Control-to-PC latency: 1 cycle.
- First valid fetch: cycle after Reset deasserts + 1 (BOOT cycle), at RESET_PC.
- Reset values: Addr=RESET_PC, PcPlus4=RESET_PC+4, FetchValid=0, Fault=0, Retired=0.
- Reset asserted mid-stall or mid-fault: reset wins, same edge.
- Stall and a taken branch/jump in the same cycle: stall wins; redirect re-evaluated next cycle with the same Inst.

## Configuration
- PC_FAULT_EN defined: in RUN with Stall=0, if NextPc[1:0]!=0 or NextPc>=DEPTH*4, go to FAULT instead of loading it. FAULT: PC holds faulting instruction address, Fault=1, FetchValid=0, Retired holds (faulting instruction not counted); exit only by Reset.
- PC_FAULT_EN undefined: no FAULT state; NextPc loaded with bits [1:0] forced to 0; out-of-range addresses pass through (memory aliases); Fault tied 0.

## Test plan
- Reset release -> one cycle Addr=0, FetchValid=0; then Addr 0x00, 0x04, 0x08 on successive edges, Retired 0,1,2.
- At Addr=0x0C, Inst=32'h10220001, Branch=1 -> next Addr=0x14; same with Branch=0 -> 0x10.
- At Addr=0x5C, Inst=32'h08000019, Jump=1 -> next Addr=0x64; Jump=1 with JumpReg=1, RegTarget=0x10 -> next Addr=0x10 (jr priority).
- Stall=1 for 3 cycles at Addr=0x20 with Branch=1 -> Addr, Retired unchanged; Stall drops -> branch applied.
- With PC_FAULT_EN: JumpReg=1, RegTarget=0x22222222 -> Fault=1, FetchValid=0, Addr held; Reset clears. Without: RegTarget=0x23 -> Addr=0x20, Fault=0.
- Branch with Inst[15:0]=16'hFFFF at Addr=0x08 -> next Addr=0x08 (self-loop, negative offset).
